// File: rtl/rotation_3d.sv
// rotation_3d
//   Rotates a signed fixed-point 3D point about X, then Y, then Z. Each axis
//   angle arrives as a sin/cos pair in Q1.(PW-1). The angles are captured
//   together with the point and travel down the pipeline with it. There is
//   no backpressure, so the pipeline accepts one point per clock.
//
//   Timing: a point is sampled at edge N and is registered into the capture
//   stage. The X, Y and Z rotation stages then register it on edges N+1,
//   N+2 and N+3, so it appears on rot_out with valid_out=1 after edge N+3.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   valid_in   rot_in/sin/cos carry a valid point this cycle
//   rot_in     input point, index 0=x, 1=y, 2=z (signed integers)
//   sin, cos   per-axis angle, index 0=X, 1=Y, 2=Z (signed Q1.(PW-1))
//   rot_out    rotated point, same layout as rot_in
//   valid_out  rot_out holds a new result this cycle
module rotation_3d #(
  parameter int POINT_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [2:0][POINT_WIDTH-1:0] rot_in,
  input  logic [2:0][POINT_WIDTH-1:0] sin,
  input  logic [2:0][POINT_WIDTH-1:0] cos,
  output logic [2:0][POINT_WIDTH-1:0] rot_out,
  output logic                        valid_out
);

  localparam int PW = POINT_WIDTH;
  localparam int AW = 2*PW + 2;

  typedef logic signed [PW-1:0]   word_t;
  typedef logic signed [2*PW-1:0] prod_t;
  typedef logic signed [AW-1:0]   acc_t;

  localparam acc_t HALF = acc_t'(1) << (PW-2);
  localparam acc_t MAXV = acc_t'((1 << (PW-1)) - 1);
  localparam acc_t MINV = ~MAXV;

  // Operands are sign-extended explicitly, so the product is exact at full width.
  function automatic prod_t smul(input word_t a, input word_t b);
    prod_t aw;
    prod_t bw;
    aw = {{PW{a[PW-1]}}, a};
    bw = {{PW{b[PW-1]}}, b};
    return aw * bw;
  endfunction

  function automatic acc_t ext(input prod_t p);
    return {{2{p[2*PW-1]}}, p};
  endfunction

  // Round half up, then drop the Q fraction and saturate to the word range.
  function automatic word_t rnd(input acc_t v);
    acc_t  t;
    word_t r;
    t = (v + HALF) >>> (PW-1);
    if (t > MAXV)      r = MAXV[PW-1:0];
    else if (t < MINV) r = MINV[PW-1:0];
    else               r = t[PW-1:0];
    return r;
  endfunction

  // A plane rotation of (a,b) by angle (s,c) gives the pair
  // a' = a*c - b*s and b' = a*s + b*c.
  // Each axis stage picks its (a,b) so that these match that axis's formulas.
  function automatic word_t rot_a(input word_t a, input word_t b,
                                  input word_t s, input word_t c);
    return rnd(ext(smul(a, c)) - ext(smul(b, s)));
  endfunction

  function automatic word_t rot_b(input word_t a, input word_t b,
                                  input word_t s, input word_t c);
    return rnd(ext(smul(a, s)) + ext(smul(b, c)));
  endfunction

  logic               v0, v1, v2;
  logic [2:0][PW-1:0] pt0, pt1, pt2;
  logic [2:0][PW-1:0] sin0, cos0;
  logic [2:1][PW-1:0] sin1, cos1;
  logic [PW-1:0]      sin2, cos2;

  word_t y1, z1, x2, z2, x3, y3;

  always_comb begin
    // X axis: (a,b) = (y,z)
    y1 = rot_a(pt0[1], pt0[2], sin0[0], cos0[0]);
    z1 = rot_b(pt0[1], pt0[2], sin0[0], cos0[0]);
    // Y axis: (a,b) = (z,x)
    z2 = rot_a(pt1[2], pt1[0], sin1[1], cos1[1]);
    x2 = rot_b(pt1[2], pt1[0], sin1[1], cos1[1]);
    // Z axis: (a,b) = (x,y)
    x3 = rot_a(pt2[0], pt2[1], sin2, cos2);
    y3 = rot_b(pt2[0], pt2[1], sin2, cos2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      pt0       <= '0;
      pt1       <= '0;
      pt2       <= '0;
      sin0      <= '0;
      cos0      <= '0;
      sin1      <= '0;
      cos1      <= '0;
      sin2      <= '0;
      cos2      <= '0;
      rot_out   <= '0;
    end else begin
      v0        <= valid_in;
      v1        <= v0;
      v2        <= v1;
      valid_out <= v2;

      // Data registers hold on bubbles; only the valid bits move every cycle.
      if (valid_in) begin
        pt0  <= rot_in;
        sin0 <= sin;
        cos0 <= cos;
      end
      if (v0) begin
        pt1  <= {z1, y1, pt0[0]};
        sin1 <= sin0[2:1];
        cos1 <= cos0[2:1];
      end
      if (v1) begin
        pt2  <= {z2, pt1[1], x2};
        sin2 <= sin1[2];
        cos2 <= cos1[2];
      end
      if (v2) begin
        rot_out <= {pt2[2], y3, x3};
      end
    end
  end

endmodule

// File: tb/tb_rotation_3d.sv
module tb_rotation_3d;

  localparam int PW = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic [2:0][PW-1:0] rot_in;
  logic [2:0][PW-1:0] sin;
  logic [2:0][PW-1:0] cos;
  logic [2:0][PW-1:0] rot_out;
  logic               valid_out;

  rotation_3d #(.POINT_WIDTH(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .rot_in    (rot_in),
    .sin       (sin),
    .cos       (cos),
    .rot_out   (rot_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px, py, pz;
    int s0, s1, s2;
    int c0, c1, c2;
    int ex, ey, ez;
  } vec_t;

  typedef struct {
    int ex, ey, ez;
    int due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   last_x = 0, last_y = 0, last_z = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference: integer arithmetic with floor shift, independent of the RTL structure.
  function automatic int rr(input int v);
    int t;
    t = (v + 1024) >>> 11;
    if (t > 2047)  t = 2047;
    if (t < -2048) t = -2048;
    return t;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t o;
    int x1, y1, z1, x2, y2, z2;
    o  = v;
    x1 = v.px;
    y1 = rr(v.py * v.c0 - v.pz * v.s0);
    z1 = rr(v.py * v.s0 + v.pz * v.c0);
    y2 = y1;
    x2 = rr(x1 * v.c1 + z1 * v.s1);
    z2 = rr(z1 * v.c1 - x1 * v.s1);
    o.ez = z2;
    o.ex = rr(x2 * v.c2 - y2 * v.s2);
    o.ey = rr(x2 * v.s2 + y2 * v.c2);
    return o;
  endfunction

  // Drives one input cycle; a valid point with reset released is queued as expected.
  task automatic send(input logic v, input vec_t d);
    valid_in  = v;
    rot_in[0] = 12'(d.px);
    rot_in[1] = 12'(d.py);
    rot_in[2] = 12'(d.pz);
    sin[0] = 12'(d.s0); sin[1] = 12'(d.s1); sin[2] = 12'(d.s2);
    cos[0] = 12'(d.c0); cos[1] = 12'(d.c1); cos[2] = 12'(d.c2);
    if (v && rst) q.push_back('{d.ex, d.ey, d.ez, cyc + 4});
  endtask

  task automatic tick();
    logic was_reset;
    int ox, oy, oz;
    exp_t e;
    was_reset = !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (was_reset) begin
      q.delete();
      last_x = 0; last_y = 0; last_z = 0;
    end
    ox = int'($signed(rot_out[0]));
    oy = int'($signed(rot_out[1]));
    oz = int'($signed(rot_out[2]));
    if (valid_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency_cycle", cyc, e.due);
        chk("out_x", ox, e.ex);
        chk("out_y", oy, e.ey);
        chk("out_z", oz, e.ez);
        last_x = e.ex; last_y = e.ey; last_z = e.ez;
      end
    end else begin
      chk("valid_out_known", int'(valid_out === 1'b0), 1);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_output_at_due", cyc, q[0].due - 1);
        void'(q.pop_front());
      end
      chk("hold_x", ox, last_x);
      chk("hold_y", oy, last_y);
      chk("hold_z", oz, last_z);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("queue_drained", q.size(), 0);
  endtask

  vec_t idle_v = '{0, 0, 0, 0, 0, 0, 2047, 2047, 2047, 0, 0, 0};
  vec_t tbl[6];
  vec_t rv;

  initial begin
    tbl[0] = '{1024, 0, 0,      0, 0, 0,        2047, 2047, 2047,  1024, 0, 0};
    tbl[1] = '{1024, 0, 0,      0, 0, 2047,     2047, 2047, 0,     0, 1024, 0};
    tbl[2] = '{2047, 2047, 0,   0, 0, 1448,     2047, 2047, 1448,  0, 2047, 0};
    tbl[3] = '{0, 1024, 0,      2047, 0, 0,     0, 2047, 2047,     0, 0, 1024};
    tbl[4] = '{0, 0, 1024,      0, 2047, 0,     2047, 0, 2047,     1024, 0, 0};
    tbl[5] = '{0, -2047, -2047, -1448, 0, 0,    1448, 2047, 2047,  0, -2047, 0};

    // Reset held for two edges, then idle with reset released.
    rst = 1'b0;
    send(1'b0, idle_v);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_valid_out", int'(valid_out), 0);
      chk("reset_rot_out", int'(rot_out), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_valid_out", int'(valid_out), 0);
      chk("idle_rot_out", int'(rot_out), 0);
    end

    // Single isolated point: exactly one valid cycle, three edges after sampling.
    send(1'b1, tbl[0]);
    tick();
    send(1'b0, idle_v);
    for (int i = 0; i < 6; i++) tick();
    chk("single_point_consumed", q.size(), 0);

    // Table vectors back to back, then one with bubbles between them.
    for (int i = 0; i < 6; i++) begin
      send(1'b1, tbl[i]);
      tick();
    end
    send(1'b0, idle_v);
    drain();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, tbl[5 - i]);
      tick();
      send(1'b0, idle_v);
      tick();
    end
    drain();
    for (int i = 0; i < 3; i++) tick();

    // Twenty consecutive random points with angles changing every cycle.
    for (int i = 0; i < 20; i++) begin
      rv.px = $urandom_range(4095) - 2048;
      rv.py = $urandom_range(4095) - 2048;
      rv.pz = $urandom_range(4095) - 2048;
      rv.s0 = $urandom_range(4095) - 2048;
      rv.s1 = $urandom_range(4095) - 2048;
      rv.s2 = $urandom_range(4095) - 2048;
      rv.c0 = $urandom_range(4095) - 2048;
      rv.c1 = $urandom_range(4095) - 2048;
      rv.c2 = $urandom_range(4095) - 2048;
      rv = model(rv);
      send(1'b1, rv);
      tick();
    end
    send(1'b0, idle_v);
    drain();

    // Random stream with bubbles, changing the live angles during bubbles.
    for (int i = 0; i < 30; i++) begin
      rv.px = $urandom_range(4095) - 2048;
      rv.py = $urandom_range(4095) - 2048;
      rv.pz = $urandom_range(4095) - 2048;
      rv.s0 = $urandom_range(4095) - 2048;
      rv.s1 = $urandom_range(4095) - 2048;
      rv.s2 = $urandom_range(4095) - 2048;
      rv.c0 = $urandom_range(4095) - 2048;
      rv.c1 = $urandom_range(4095) - 2048;
      rv.c2 = $urandom_range(4095) - 2048;
      rv = model(rv);
      send(logic'($urandom_range(1)), rv);
      tick();
    end
    send(1'b0, idle_v);
    drain();

    // Reset while points are in flight: nothing stale may come out afterwards.
    for (int i = 0; i < 3; i++) begin
      send(1'b1, tbl[i]);
      tick();
    end
    rst = 1'b0;
    send(1'b1, tbl[3]);
    tick();
    chk("midreset_valid_out", int'(valid_out), 0);
    chk("midreset_rot_out", int'(rot_out), 0);
    rst = 1'b1;
    send(1'b0, idle_v);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_reset_no_stale", int'(valid_out), 0);
    end

    // Pipeline still works after the flush.
    send(1'b1, tbl[1]);
    tick();
    send(1'b0, idle_v);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
